// File: rtl/fp_mult_param_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mult_param_pipe
//  Brief    : 3-stage IEEE-754-style multiplier, flush-to-zero, RNE rounding.
//  Revision : 1.0
// ============================================================================
module fp_mult_param_pipe #(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 23,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] result,
   output logic         done,
   input  logic         out_ready,
   output logic         overflow,
   output logic         underflow,
   output logic         invalid
);

   localparam int                      c_pw       = 2 * MAN_W + 2;
   localparam logic signed [EXP_W+1:0] c_bias     = (EXP_W+2)'(2**(EXP_W-1) - 1);
   localparam logic signed [EXP_W+1:0] c_emax     = (EXP_W+2)'(2**EXP_W - 1);
   localparam logic signed [EXP_W+1:0] c_ezero    = '0;
   localparam logic [1:0]              c_cls_norm = 2'd0;
   localparam logic [1:0]              c_cls_zero = 2'd1;
   localparam logic [1:0]              c_cls_inf  = 2'd2;
   localparam logic [1:0]              c_cls_nan  = 2'd3;

   logic w_adv;
   assign w_adv    = out_ready | ~done;
   assign in_ready = w_adv;

   // ---------------- stage 1: unpack and classify ----------------
   logic [EXP_W-1:0] w_ea, w_eb;
   logic [MAN_W-1:0] w_fa, w_fb;
   logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
   logic [1:0]       w_cls;

   assign w_ea     = a[W-2:MAN_W];
   assign w_eb     = b[W-2:MAN_W];
   assign w_fa     = a[MAN_W-1:0];
   assign w_fb     = b[MAN_W-1:0];
   assign w_a_zero = ~|w_ea;
   assign w_b_zero = ~|w_eb;
   assign w_a_nan  = (&w_ea) & (|w_fa);
   assign w_b_nan  = (&w_eb) & (|w_fb);
   assign w_a_inf  = (&w_ea) & ~(|w_fa);
   assign w_b_inf  = (&w_eb) & ~(|w_fb);

   always_comb begin
      w_cls = c_cls_norm;
      if (w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_a_zero & w_b_inf))
         w_cls = c_cls_nan;
      else if (w_a_inf | w_b_inf)
         w_cls = c_cls_inf;
      else if (w_a_zero | w_b_zero)
         w_cls = c_cls_zero;
   end

   logic             r1_valid, r1_sign;
   logic [1:0]       r1_cls;
   logic [EXP_W-1:0] r1_ea, r1_eb;
   logic [MAN_W:0]   r1_ma, r1_mb;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r1_valid <= 1'b0;
      end else if (w_adv) begin
         r1_valid <= start;
         r1_sign  <= a[W-1] ^ b[W-1];
         r1_cls   <= w_cls;
         r1_ea    <= w_ea;
         r1_eb    <= w_eb;
         r1_ma    <= {1'b1, w_fa};
         r1_mb    <= {1'b1, w_fb};
      end
   end

   // ---------------- stage 2: mantissa multiply, exponent sum ----------------
   logic [c_pw-1:0]         w_prod;
   logic signed [EXP_W+1:0] w_esum;

   assign w_prod = {{(MAN_W+1){1'b0}}, r1_ma} * {{(MAN_W+1){1'b0}}, r1_mb};
   assign w_esum = $signed({2'b00, r1_ea}) + $signed({2'b00, r1_eb}) - c_bias;

   logic                    r2_valid, r2_sign;
   logic [1:0]              r2_cls;
   logic [c_pw-1:0]         r2_prod;
   logic signed [EXP_W+1:0] r2_exp;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r2_valid <= 1'b0;
      end else if (w_adv) begin
         r2_valid <= r1_valid;
         r2_sign  <= r1_sign;
         r2_cls   <= r1_cls;
         r2_prod  <= w_prod;
         r2_exp   <= w_esum;
      end
   end

   // ---------------- stage 3: normalise, round, pack ----------------
   logic                    w_norm, w_guard, w_round, w_sticky, w_up, w_carry;
   logic [MAN_W:0]          w_mant;
   logic [MAN_W+1:0]        w_mant_r;
   logic [MAN_W-1:0]        w_frac;
   logic signed [EXP_W+1:0] w_e1, w_efin;

   assign w_norm   = r2_prod[c_pw-1];
   assign w_mant   = w_norm ? r2_prod[c_pw-1:MAN_W+1] : r2_prod[c_pw-2:MAN_W];
   assign w_guard  = w_norm ? r2_prod[MAN_W]   : r2_prod[MAN_W-1];
   assign w_round  = w_norm ? r2_prod[MAN_W-1] : r2_prod[MAN_W-2];
   assign w_sticky = w_norm ? |r2_prod[MAN_W-2:0] : |r2_prod[MAN_W-3:0];
   // Round half to even: ties go up only when the kept LSB is odd.
   assign w_up     = w_guard & (w_round | w_sticky | w_mant[0]);
   assign w_mant_r = {1'b0, w_mant} + {{(MAN_W+1){1'b0}}, w_up};
   assign w_carry  = w_mant_r[MAN_W+1];
   assign w_frac   = w_carry ? w_mant_r[MAN_W:1] : w_mant_r[MAN_W-1:0];
   assign w_e1     = r2_exp + $signed({{(EXP_W+1){1'b0}}, w_norm});
   assign w_efin   = w_e1 + $signed({{(EXP_W+1){1'b0}}, w_carry});

   logic [W-1:0] w_res;
   logic         w_ovf, w_unf, w_inv;

   always_comb begin
      w_res = '0;
      w_ovf = 1'b0;
      w_unf = 1'b0;
      w_inv = 1'b0;
      case (r2_cls)
         c_cls_nan: begin
            w_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            w_inv = 1'b1;
         end
         c_cls_inf:  w_res = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         c_cls_zero: w_res = {r2_sign, {(W-1){1'b0}}};
         default: begin
            if (w_efin >= c_emax) begin
               w_res = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               w_ovf = 1'b1;
            end else if (w_efin <= c_ezero) begin
               w_res = {r2_sign, {(W-1){1'b0}}};
               w_unf = 1'b1;
            end else begin
               w_res = {r2_sign, w_efin[EXP_W-1:0], w_frac};
            end
         end
      endcase
   end

   logic [W-1:0] r_result;
   logic         r_done, r_ovf, r_unf, r_inv;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_result <= '0;
         r_done   <= 1'b0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
         r_inv    <= 1'b0;
      end else if (w_adv) begin
         r_done <= r2_valid;
         r_ovf  <= r2_valid & w_ovf;
         r_unf  <= r2_valid & w_unf;
         r_inv  <= r2_valid & w_inv;
         if (r2_valid)
            r_result <= w_res;
      end
   end

   assign result    = r_result;
   assign done      = r_done;
   assign overflow  = r_ovf;
   assign underflow = r_unf;
   assign invalid   = r_inv;

endmodule
`default_nettype wire

// File: tb/tb_fp_mult_param_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_mult_param_pipe
//  Brief    : Directed self-checking bench for fp_mult_param_pipe (fp32 and fp16).
//  Revision : 1.0
// ============================================================================
module tb_fp_mult_param_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, out_ready;
   logic [31:0] a, b;
   wire         in_ready, done, ovf, unf, inv;
   wire  [31:0] result;

   logic        start_h, out_ready_h;
   logic [15:0] a_h, b_h;
   wire         in_ready_h, done_h, ovf_h, unf_h, inv_h;
   wire  [15:0] result_h;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fp_mult_param_pipe u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_ready(in_ready),
      .a(a), .b(b), .result(result), .done(done), .out_ready(out_ready),
      .overflow(ovf), .underflow(unf), .invalid(inv)
   );

   fp_mult_param_pipe #(.EXP_W(5), .MAN_W(10)) u_dut_h (
      .clk(clk), .rst_n(rst_n), .start(start_h), .in_ready(in_ready_h),
      .a(a_h), .b(b_h), .result(result_h), .done(done_h), .out_ready(out_ready_h),
      .overflow(ovf_h), .underflow(unf_h), .invalid(inv_h)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Single pair through an idle pipe; flags are {overflow, underflow, invalid}.
   task automatic run_vec(input bit half, input string tag, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] er, input logic [2:0] ef);
      int n;
      if (half) begin
         a_h = av[15:0]; b_h = bv[15:0]; start_h = 1'b1;
      end else begin
         a = av; b = bv; start = 1'b1;
      end
      tick;
      start   = 1'b0;
      start_h = 1'b0;
      n = 0;
      while (!(half ? done_h : done) && n < 8) begin
         tick;
         n++;
      end
      chk({tag, ".done"}, half ? done_h : done, 1);
      chk({tag, ".lat"}, n, 2);
      chk({tag, ".res"}, half ? {16'h0, result_h} : result, er);
      chk({tag, ".flags"}, half ? {ovf_h, unf_h, inv_h} : {ovf, unf, inv}, ef);
      tick;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; out_ready = 1'b1; a = '0; b = '0;
      start_h = 1'b0; out_ready_h = 1'b1; a_h = '0; b_h = '0;
      repeat (2) tick;
      chk("rst.done", done, 0);
      chk("rst.result", result, 0);
      chk("rst.flags", {ovf, unf, inv}, 0);
      chk("rst.done_h", done_h, 0);
      rst_n = 1'b1;
      chk("rst.in_ready", in_ready, 1);
      tick;

      // back-to-back stream with latency check
      a = 32'h40000000; b = 32'h40400000; start = 1'b1; tick;
      chk("str.lat0", done, 0);
      a = 32'hC0000000; b = 32'h40400000; tick;
      chk("str.lat1", done, 0);
      a = 32'h3FC00000; b = 32'h3FC00000; tick;
      start = 1'b0;
      chk("str.d1", done, 1);
      chk("str.r1", result, 32'h40C00000);
      tick;
      chk("str.d2", done, 1);
      chk("str.r2", result, 32'hC0C00000);
      tick;
      chk("str.d3", done, 1);
      chk("str.r3", result, 32'h40100000);
      tick;
      chk("str.drop", done, 0);
      chk("str.flags0", {ovf, unf, inv}, 0);

      run_vec(0, "rne_up",  32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000);
      run_vec(0, "rne_tie", 32'h3F800800, 32'h3F800800, 32'h3F801000, 3'b000);
      run_vec(0, "rne_odd", 32'h3F800800, 32'h3F801800, 32'h3F802002, 3'b000);
      run_vec(0, "ovf",     32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100);
      run_vec(0, "unf",     32'h00800000, 32'h00800000, 32'h00000000, 3'b010);
      run_vec(0, "inf0",    32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001);
      run_vec(0, "zinf",    32'h00000000, 32'hFF800000, 32'h7FC00000, 3'b001);
      run_vec(0, "sub",     32'h007FFFFF, 32'h40000000, 32'h00000000, 3'b000);
      run_vec(0, "nan",     32'hFFC00000, 32'h3F800000, 32'h7FC00000, 3'b001);
      run_vec(0, "inf3",    32'h7F800000, 32'h40400000, 32'h7F800000, 3'b000);
      run_vec(0, "ninfinf", 32'hFF800000, 32'h7F800000, 32'hFF800000, 3'b000);
      run_vec(0, "nzero",   32'h80000000, 32'h40A00000, 32'h80000000, 3'b000);

      // backpressure: hold the first result for 4 cycles
      a = 32'h40000000; b = 32'h40400000; start = 1'b1; tick;
      a = 32'h3FC00000; b = 32'h3FC00000; tick;
      a = 32'h3F800000; b = 32'h40A00000; tick;
      start = 1'b0;
      chk("bp.d1", done, 1);
      chk("bp.r1", result, 32'h40C00000);
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("bp.hold_done", done, 1);
         chk("bp.hold_res", result, 32'h40C00000);
         chk("bp.hold_rdy", in_ready, 0);
      end
      out_ready = 1'b1;
      tick;
      chk("bp.d2", done, 1);
      chk("bp.r2", result, 32'h40100000);
      tick;
      chk("bp.d3", done, 1);
      chk("bp.r3", result, 32'h40A00000);
      tick;
      chk("bp.drop", done, 0);

      // reset with two pairs in flight
      a = 32'h40000000; b = 32'h40400000; start = 1'b1; tick;
      a = 32'h3FC00000; b = 32'h3FC00000; tick;
      start = 1'b0;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      chk("mrst.done", done, 0);
      chk("mrst.result", result, 0);
      chk("mrst.flags", {ovf, unf, inv}, 0);
      chk("mrst.in_ready", in_ready, 1);
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("mrst.no_done", done, 0);
      end

      run_vec(1, "h_mul", 32'h4000, 32'h4200, 32'h4600, 3'b000);
      run_vec(1, "h_ovf", 32'h7800, 32'h7800, 32'h7C00, 3'b100);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
